rf_op_sequencer: RTL and testbench



---
 rtl/rf_op_sequencer.sv | 122 ++++++++++++
 tb/tb_rf_op_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer.sv
// Four-state micro-op sequencer for the 8x4 register file: READ -> EXEC -> WRITE.
// Define RF_ZERO_REG_EN to make r0 read as zero and never be written.
module rf_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs1,
    input  logic [2:0] cmd_rs2,
    input  logic [3:0] cmd_imm,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic [2:0] rf_raddr1,
    output logic [2:0] rf_raddr2,
    output logic [3:0] rf_wdata,
    input  logic [3:0] rf_rdata1,
    input  logic [3:0] rf_rdata2,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       carry
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010,
                           OP_AND = 3'b011, OP_OR  = 3'b100, OP_XOR = 3'b101,
                           OP_LDI = 3'b110, OP_MOV = 3'b111;

    state_t     r_state, w_next;
    logic [2:0] r_op, r_rd, r_rs1, r_rs2, r_waddr;
    logic [3:0] r_imm, r_a, r_b, r_result, r_wdata;
    logic       r_carry;
    logic [3:0] w_res, w_opa, w_opb;
    logic       w_carry, w_wr_ok;

`ifdef RF_ZERO_REG_EN
    assign w_opa   = (r_rs1 == 3'd0) ? 4'h0 : rf_rdata1;
    assign w_opb   = (r_rs2 == 3'd0) ? 4'h0 : rf_rdata2;
    assign w_wr_ok = (r_rd != 3'd0);
`else
    assign w_opa   = rf_rdata1;
    assign w_opb   = rf_rdata2;
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_next = READ;
            READ:    w_next = EXEC;
            EXEC:    w_next = WRITE;
            default: w_next = IDLE;
        endcase
    end

    // NOP leaves result/carry untouched, so the defaults are the held values
    always_comb begin
        w_res   = r_result;
        w_carry = r_carry;
        case (r_op)
            OP_ADD: {w_carry, w_res} = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB: begin
                w_res   = r_a - r_b;
                w_carry = (r_a < r_b);
            end
            OP_AND: begin w_res = r_a & r_b; w_carry = 1'b0; end
            OP_OR:  begin w_res = r_a | r_b; w_carry = 1'b0; end
            OP_XOR: begin w_res = r_a ^ r_b; w_carry = 1'b0; end
            OP_LDI: begin w_res = r_imm;     w_carry = 1'b0; end
            OP_MOV: begin w_res = r_a;       w_carry = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0; r_rd <= '0; r_rs1 <= '0; r_rs2 <= '0; r_imm <= '0;
            r_a <= '0; r_b <= '0; r_result <= '0; r_carry <= 1'b0;
            r_waddr <= '0; r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_op  <= cmd_op;
                    r_rd  <= cmd_rd;
                    r_rs1 <= cmd_rs1;
                    r_rs2 <= cmd_rs2;
                    r_imm <= cmd_imm;
                end
                READ: begin
                    r_a <= w_opa;
                    r_b <= w_opb;
                end
                EXEC: begin
                    r_result <= w_res;
                    r_carry  <= w_carry;
                    r_waddr  <= r_rd;
                    r_wdata  <= w_res;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rf_raddr1 = r_rs1;
    assign rf_raddr2 = r_rs2;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign result    = r_result;
    assign carry     = r_carry;
    // gated by ~rst so a reset landing in WRITE never commits to the register file
    assign done  = (r_state == WRITE) & ~rst;
    assign rf_we = done & (r_op != OP_NOP) & w_wr_ok;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Table-driven bench for rf_op_sequencer with a behavioural 8x4 register file and scoreboard.
module tb_rf_op_sequencer;
    logic       clk = 1'b0, rst = 1'b1, rf_clr = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_op = '0, cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [3:0] cmd_imm = '0;
    logic       rf_we, busy, done, carry;
    logic [2:0] rf_waddr, rf_raddr1, rf_raddr2;
    logic [3:0] rf_wdata, rf_rdata1, rf_rdata2, result;
    logic [3:0] tb_rf [8];

    int errs = 0, checks = 0;

    localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                           OR_ = 3'd4, XOR_ = 3'd5, LDI = 3'd6, MOV = 3'd7;

    typedef struct {
        logic [2:0] op, rd, rs1, rs2;
        logic [3:0] imm;
        logic       we;
        logic [3:0] wdata, res;
        logic       c;
    } vec_t;

    typedef struct {
        logic       we;
        logic [2:0] waddr;
        logic [3:0] wdata, res;
        logic       c, chk_wdata;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) for (int i = 0; i < 8; i++) tb_rf[i] <= 4'h0;
        else if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata1 = tb_rf[rf_raddr1];
    assign rf_rdata2 = tb_rf[rf_raddr2];

    rf_op_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .busy(busy), .done(done), .result(result), .carry(carry)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        cmd_op = v.op; cmd_rd = v.rd; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_imm = v.imm;
        cmd_valid = 1'b1;
        sb.push_back('{we: v.we, waddr: v.rd, wdata: v.wdata, res: v.res, c: v.c,
                       chk_wdata: (v.op != NOP)});
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        if (lat == 0) begin
            checks++; errs++;
            $display("FAIL done_timeout: got no done within 8 cycles");
        end
    endtask

    task automatic check_done(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errs++;
            $display("FAIL %s_sb: got done with empty scoreboard", nm);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_done"}, {7'd0, done}, 8'd1);
        chk({nm, "_we"}, {7'd0, rf_we}, {7'd0, e.we});
        chk({nm, "_waddr"}, {5'd0, rf_waddr}, {5'd0, e.waddr});
        if (e.chk_wdata) chk({nm, "_wdata"}, {4'd0, rf_wdata}, {4'd0, e.wdata});
        chk({nm, "_result"}, {4'd0, result}, {4'd0, e.res});
        chk({nm, "_carry"}, {7'd0, carry}, {7'd0, e.c});
    endtask

    task automatic wait_ready();
        @(negedge clk);
        for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
        if (!cmd_ready) begin
            checks++; errs++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1");
        end
    endtask

    task automatic issue(input vec_t v, input string nm);
        int lat;
        wait_ready();
        drive(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(lat);
        chk({nm, "_latency"}, lat[7:0], 8'd3);
        if (lat != 0) check_done(nm);
        @(negedge clk);
        chk({nm, "_ready_c4"}, {7'd0, cmd_ready}, 8'd1);
        chk({nm, "_done_c4"}, {7'd0, done}, 8'd0);
    endtask

    initial begin
        int lat;
        vec_t v;
        tbl[0]  = '{LDI,  3'd3, 3'd0, 3'd0, 4'h9, 1'b1, 4'h9, 4'h9, 1'b0};
        tbl[1]  = '{LDI,  3'd1, 3'd0, 3'd0, 4'hC, 1'b1, 4'hC, 4'hC, 1'b0};
        tbl[2]  = '{LDI,  3'd2, 3'd0, 3'd0, 4'h7, 1'b1, 4'h7, 4'h7, 1'b0};
        tbl[3]  = '{ADD,  3'd4, 3'd1, 3'd2, 4'h0, 1'b1, 4'h3, 4'h3, 1'b1};
        tbl[4]  = '{SUB,  3'd5, 3'd2, 3'd1, 4'h0, 1'b1, 4'hB, 4'hB, 1'b1};
        tbl[5]  = '{SUB,  3'd5, 3'd1, 3'd2, 4'h0, 1'b1, 4'h5, 4'h5, 1'b0};
        tbl[6]  = '{AND_, 3'd6, 3'd1, 3'd2, 4'h0, 1'b1, 4'h4, 4'h4, 1'b0};
        tbl[7]  = '{OR_,  3'd7, 3'd1, 3'd2, 4'h0, 1'b1, 4'hF, 4'hF, 1'b0};
        tbl[8]  = '{MOV,  3'd3, 3'd4, 3'd0, 4'h0, 1'b1, 4'h3, 4'h3, 1'b0};
        tbl[9]  = '{ADD,  3'd3, 3'd3, 3'd3, 4'h0, 1'b1, 4'h6, 4'h6, 1'b0};
`ifdef RF_ZERO_REG_EN
        tbl[10] = '{LDI,  3'd0, 3'd0, 3'd0, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0};
        tbl[11] = '{MOV,  3'd2, 3'd0, 3'd0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0};
`else
        tbl[10] = '{LDI,  3'd0, 3'd0, 3'd0, 4'hF, 1'b1, 4'hF, 4'hF, 1'b0};
        tbl[11] = '{MOV,  3'd2, 3'd0, 3'd0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b0};
`endif
        tbl[12] = '{ADD,  3'd1, 3'd1, 3'd1, 4'h0, 1'b1, 4'h8, 4'h8, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_we", {7'd0, rf_we}, 8'd0);
        chk("rst_result", {3'd0, carry, result}, 8'd0);
        chk("rst_addr", {rf_waddr, rf_raddr1, 2'd0}, 8'd0);
        chk("rst_wdata", {4'd0, rf_wdata}, 8'd0);
        rst = 1'b0; rf_clr = 1'b0;

        for (int i = 0; i < 13; i++) issue(tbl[i], $sformatf("vec%0d", i));

        // NOP with cmd_valid held, XOR queued behind it: accept exactly 4 cycles later
        wait_ready();
        v = '{NOP, 3'd1, 3'd1, 3'd1, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1};
        drive(v);
        @(posedge clk);
        repeat (3) @(negedge clk);
        check_done("nop");
        v = '{XOR_, 3'd1, 3'd1, 3'd1, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0};
        drive(v);
        @(negedge clk);
        chk("nop_ready_c4", {7'd0, cmd_ready}, 8'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("xor_accept_c4", {7'd0, busy}, 8'd1);
        wait_done(lat);
        chk("xor_latency", lat[7:0], 8'd2);
        if (lat != 0) check_done("xor");
        @(negedge clk);
        chk("xor_r1", {4'd0, tb_rf[1]}, 8'h00);

        // reset arriving in the WRITE cycle of ADD r6
        wait_ready();
        cmd_op = ADD; cmd_rd = 3'd6; cmd_rs1 = 3'd3; cmd_rs2 = 3'd3; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_write", {7'd0, done}, 8'd1);
        rst = 1'b1;
        #1;
        chk("abort_we", {7'd0, rf_we}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
        chk("abort_result", {3'd0, carry, result}, 8'd0);
        chk("abort_r6", {4'd0, tb_rf[6]}, 8'h04);

        chk("rf_r3", {4'd0, tb_rf[3]}, 8'h06);
        chk("rf_r4", {4'd0, tb_rf[4]}, 8'h03);
        chk("rf_r5", {4'd0, tb_rf[5]}, 8'h05);
        chk("rf_r7", {4'd0, tb_rf[7]}, 8'h0F);
`ifdef RF_ZERO_REG_EN
        chk("rf_r0", {4'd0, tb_rf[0]}, 8'h00);
        chk("rf_r2", {4'd0, tb_rf[2]}, 8'h00);
`else
        chk("rf_r0", {4'd0, tb_rf[0]}, 8'h0F);
        chk("rf_r2", {4'd0, tb_rf[2]}, 8'h0F);
`endif
        chk("sb_empty", sb.size(), 8'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
